// File: rtl/ahb_lite_sram_slave_if.sv
// AHB-Lite slave-side bus bundle for ahb_lite_sram_slave.
// Handshake: an address phase is taken on a rising edge where
// HSEL && HREADY && HTRANS[1]; the data phase that follows ends on the first
// rising edge where HREADY is high. HREADYOUT is this slave's contribution
// to HREADY. HWDATA is valid in the data phase, HRDATA/HRESP are meaningful
// on the cycle HREADYOUT is high.
interface ahb_lite_sram_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [1:0]  HTRANS;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;

  modport slave (
    input  HSEL, HADDR, HWRITE, HSIZE, HBURST, HTRANS, HPROT, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );

  modport master (
    output HSEL, HADDR, HWRITE, HSIZE, HBURST, HTRANS, HPROT, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM responder: word-organised memory, WAIT_STATES wait cycles per
// OKAY transfer, byte/half/word writes with little-endian lanes.
// Optional feature macro: AHB_SRAM_ERR_EN. When defined, out-of-range and
// misaligned accesses get a two-cycle ERROR response. When undefined,
// out-of-range reads return zero, out-of-range writes are dropped, misaligned
// accesses are forced to size alignment, and HRESP is always OKAY.
module ahb_lite_sram_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  ahb_lite_sram_slave_if.slave        bus,
  output logic [2:0]                  dbg_state
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS) * 32'd4;
  localparam logic [3:0]  WS   = 4'(WAIT_STATES);

  // Elaboration-time parameter sanity.
  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
    $error("ahb_lite_sram_slave: WAIT_STATES must be 0..15");
  end
  if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
    $error("ahb_lite_sram_slave: DEPTH_WORDS must be a power of two >= 2");
  end

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2
`ifdef AHB_SRAM_ERR_EN
    ,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
`endif
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           capture;

  // Address-phase registers for the transfer now in its data phase.
  logic           wr_q;
  logic [3:0]     be_q;
  logic [AW-1:0]  widx_q;
  logic           drop_q;

  logic [31:0]    mem [DEPTH_WORDS];

  logic           accept;
  logic [31:0]    offset;
  logic           in_range;
  logic [3:0]     be_d;
  logic           unused_ok;

  assign accept    = bus.HSEL && bus.HREADY && bus.HTRANS[1];
  assign offset    = bus.HADDR - BASE_ADDR;
  assign in_range  = offset < SPAN;
  assign dbg_state = state_q;
  assign unused_ok = ^{bus.HBURST, bus.HPROT};

`ifdef AHB_SRAM_ERR_EN
  logic misaligned;
  logic err_d;
  assign misaligned = (bus.HSIZE > 3'd2) ||
                      (bus.HSIZE == 3'd1 && bus.HADDR[0]) ||
                      (bus.HSIZE == 3'd2 && bus.HADDR[1:0] != 2'b00);
  assign err_d      = !in_range || misaligned;
`endif

  // Byte lanes from size; low address bits below the size are ignored, which
  // gives the forced alignment used when errors are disabled.
  always_comb begin
    be_d = 4'b1111;
    case (bus.HSIZE)
      3'd0:    be_d = 4'b0001 << bus.HADDR[1:0];
      3'd1:    be_d = bus.HADDR[1] ? 4'b1100 : 4'b0011;
      default: be_d = 4'b1111;
    endcase
  end

  // Next state, wait counter and address-phase capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = ST_DATA;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
`ifdef AHB_SRAM_ERR_EN
      ST_ERR1: state_d = ST_ERR2;
`endif
      default: begin
        // IDLE, DATA and ERR2 drive HREADYOUT high, so a new address phase
        // may be taken here (pipelined behind the ending data phase).
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
        if (accept) begin
          capture = 1'b1;
`ifdef AHB_SRAM_ERR_EN
          if (err_d) begin
            state_d = ST_ERR1;
          end else
`endif
          if (WS != 4'd0) begin
            state_d = ST_WAIT;
            cnt_d   = WS;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
    endcase
  end

  // State, counter and captured address-phase attributes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      be_q    <= 4'b0000;
      widx_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        wr_q   <= bus.HWRITE;
        be_q   <= be_d;
        widx_q <= offset[AW+1:2];
        drop_q <= !in_range;
      end
    end
  end

  // Write commits on the edge that ends DATA; reset on that edge drops it.
  always_ff @(posedge clk) begin
    if (!rst && state_q == ST_DATA && wr_q && !drop_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[widx_q][8*i +: 8] <= bus.HWDATA[8*i +: 8];
      end
    end
  end

  // Bus response decoded from the current state.
  always_comb begin
    bus.HREADYOUT = 1'b1;
    bus.HRESP     = 2'b00;
    bus.HRDATA    = 32'h0;
    case (state_q)
      ST_WAIT: bus.HREADYOUT = 1'b0;
      ST_DATA: if (!wr_q && !drop_q) bus.HRDATA = mem[widx_q];
`ifdef AHB_SRAM_ERR_EN
      ST_ERR1: begin
        bus.HREADYOUT = 1'b0;
        bus.HRESP     = 2'b01;
      end
      ST_ERR2: bus.HRESP = 2'b01;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Bench for ahb_lite_sram_slave: one instance with zero wait states and one
// with a single wait state share the stimulus; HSEL picks the target.
module tb_ahb_lite_sram_slave;

  localparam logic [31:0] BASE  = 32'h2000_0000;
  localparam int          DEPTH = 1024;
  localparam int          WS0   = 0;
  localparam int          WS1   = 1;
`ifdef AHB_SRAM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam logic [1:0] ERESP = ERR_EN ? 2'b01 : 2'b00;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [1:0]  h_sel;
  logic [1:0]  h_trans;
  logic [31:0] h_addr;
  logic [31:0] h_wdata;
  logic        h_write;
  logic [2:0]  h_size;
  logic [2:0]  dbg0, dbg1;

  ahb_lite_sram_slave_if bus0();
  ahb_lite_sram_slave_if bus1();

  assign bus0.HSEL   = h_sel[0];
  assign bus1.HSEL   = h_sel[1];
  assign bus0.HADDR  = h_addr;    assign bus1.HADDR  = h_addr;
  assign bus0.HWRITE = h_write;   assign bus1.HWRITE = h_write;
  assign bus0.HSIZE  = h_size;    assign bus1.HSIZE  = h_size;
  assign bus0.HBURST = 3'b000;    assign bus1.HBURST = 3'b000;
  assign bus0.HTRANS = h_trans;   assign bus1.HTRANS = h_trans;
  assign bus0.HPROT  = 4'b0011;   assign bus1.HPROT  = 4'b0011;
  assign bus0.HWDATA = h_wdata;   assign bus1.HWDATA = h_wdata;
  assign bus0.HREADY = bus0.HREADYOUT;
  assign bus1.HREADY = bus1.HREADYOUT;

  ahb_lite_sram_slave #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(WS0)) u_ws0 (
    .clk(clk), .rst(rst), .bus(bus0), .dbg_state(dbg0)
  );
  ahb_lite_sram_slave #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(WS1)) u_ws1 (
    .clk(clk), .rst(rst), .bus(bus1), .dbg_state(dbg1)
  );

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic get_rdy(input int s);
    return (s == 1) ? bus1.HREADYOUT : bus0.HREADYOUT;
  endfunction
  function automatic logic [1:0] get_resp(input int s);
    return (s == 1) ? bus1.HRESP : bus0.HRESP;
  endfunction
  function automatic logic [31:0] get_rdata(input int s);
    return (s == 1) ? bus1.HRDATA : bus0.HRDATA;
  endfunction

  // ---------------- reference model ----------------
  // Memory image per instance plus the response rules: range/alignment
  // decide ERROR vs OKAY, size decides which byte lanes a write touches.
  logic [31:0] mdl [2][DEPTH];

  function automatic void model(input int s, input bit wr, input logic [31:0] addr,
                                input logic [2:0] size, input logic [31:0] wdata,
                                output logic [31:0] rd, output logic [1:0] resp,
                                output int cyc);
    logic [31:0] off;
    int          nbytes, first, widx;
    bit          outside, unaligned;
    off       = addr - BASE;
    outside   = off >= 32'(DEPTH * 4);
    nbytes    = (size >= 3'd2) ? 4 : ((size == 3'd1) ? 2 : 1);
    unaligned = (size > 3'd2) || ((addr % nbytes) != 0);
    rd        = 32'h0;
    if (ERR_EN && (outside || unaligned)) begin
      resp = 2'b01;
      cyc  = 2;
      return;
    end
    resp = 2'b00;
    cyc  = ((s == 1) ? WS1 : WS0) + 1;
    if (outside) return;
    widx  = int'(off / 4);
    first = (int'(off % 4) / nbytes) * nbytes;
    if (wr) begin
      for (int k = first; k < first + nbytes; k++) mdl[s][widx][8*k +: 8] = wdata[8*k +: 8];
    end else begin
      rd = mdl[s][widx];
    end
  endfunction

  // ---------------- driver ----------------
  // Starts #1 after a rising edge; returns #1 after the edge ending the data phase.
  task automatic xfer(input int s, input bit wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, output logic [31:0] rd, output logic [1:0] resp_first,
                      output logic [1:0] resp_last, output int cyc, output bit dirty, output bit tmo);
    h_sel   = (s == 1) ? 2'b10 : 2'b01;
    h_trans = 2'b10;
    h_addr  = addr;
    h_write = wr;
    h_size  = size;
    h_wdata = $urandom;
    @(posedge clk); #1;
    h_sel      = 2'b00;
    h_trans    = 2'b00;
    h_addr     = $urandom;
    h_wdata    = wdata;
    cyc        = 0;
    dirty      = 1'b0;
    tmo        = 1'b0;
    resp_first = 2'bxx;
    resp_last  = 2'bxx;
    rd         = 'x;
    forever begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) resp_first = get_resp(s);
      if (get_rdy(s) === 1'b1) begin
        rd        = get_rdata(s);
        resp_last = get_resp(s);
        break;
      end
      if (get_rdata(s) !== 32'h0) dirty = 1'b1;
      if (cyc >= 40) begin
        tmo = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  // Runs one transfer and compares it against explicit expectations.
  task automatic run_check(input string tag, input int s, input bit wr, input logic [31:0] addr,
                           input logic [2:0] size, input logic [31:0] wdata,
                           input logic [31:0] exp_rd, input int exp_cyc, input logic [1:0] exp_resp);
    logic [31:0] rd;
    logic [1:0]  r0, r1;
    int          cyc;
    bit          dirty, tmo;
    xfer(s, wr, addr, size, wdata, rd, r0, r1, cyc, dirty, tmo);
    chk({tag, "_timeout"}, 32'(tmo), 32'h0);
    chk({tag, "_cycles"}, cyc, exp_cyc);
    chk({tag, "_resp_first"}, 32'(r0), 32'(exp_resp));
    chk({tag, "_resp_last"}, 32'(r1), 32'(exp_resp));
    chk({tag, "_rdata_wait"}, 32'(dirty), 32'h0);
    if (!wr) chk({tag, "_rdata"}, rd, exp_rd);
  endtask

  // Runs one transfer, predicting the expectation from the model.
  task automatic run_model(input string tag, input int s, input bit wr, input logic [31:0] addr,
                           input logic [2:0] size, input logic [31:0] wdata);
    logic [31:0] erd;
    logic [1:0]  eresp;
    int          ecyc;
    model(s, wr, addr, size, wdata, erd, eresp, ecyc);
    run_check(tag, s, wr, addr, size, wdata, erd, ecyc, eresp);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int          s;
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int          exp_cyc;
    logic [1:0]  exp_resp;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input int s, input bit wr, input logic [31:0] addr, input logic [2:0] size,
                         input logic [31:0] wdata, input logic [31:0] exp_rd, input int exp_cyc,
                         input logic [1:0] exp_resp);
    vec_t v;
    v.s = s; v.wr = wr; v.addr = addr; v.size = size; v.wdata = wdata;
    v.exp_rd = exp_rd; v.exp_cyc = exp_cyc; v.exp_resp = exp_resp;
    vecs.push_back(v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [1:0]  r0, r1;
    int          cyc;
    bit          dirty, tmo;
    logic [31:0] dmy_rd;
    logic [1:0]  dmy_resp;
    int          dmy_cyc;

    h_sel = 2'b00; h_trans = 2'b00; h_addr = 32'h0; h_wdata = 32'h0;
    h_write = 1'b0; h_size = 3'd2;
    rst = 1'b1;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready0", 32'(bus0.HREADYOUT), 32'h1);
    chk("rst_ready1", 32'(bus1.HREADYOUT), 32'h1);
    chk("rst_resp0", 32'(bus0.HRESP), 32'h0);
    chk("rst_resp1", 32'(bus1.HRESP), 32'h0);
    chk("rst_rdata0", bus0.HRDATA, 32'h0);
    chk("rst_rdata1", bus1.HRDATA, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Give words 0..15 of both instances known contents.
    for (int s = 0; s < 2; s++) begin
      for (int w = 0; w < 16; w++) run_model("init", s, 1'b1, BASE + 32'(w * 4), 3'd2, $urandom);
    end

    // Directed table.
    add_vec(1, 1, BASE + 32'h10,   3'd2, 32'hDEADBEEF, 32'h0,        2, 2'b00);
    add_vec(1, 0, BASE + 32'h10,   3'd2, 32'h0,        32'hDEADBEEF, 2, 2'b00);
    add_vec(1, 1, BASE + 32'h10,   3'd2, 32'h11223344, 32'h0,        2, 2'b00);
    add_vec(1, 1, BASE + 32'h13,   3'd0, 32'hA5776655, 32'h0,        2, 2'b00);
    add_vec(1, 0, BASE + 32'h10,   3'd2, 32'h0,        32'hA5223344, 2, 2'b00);
    add_vec(1, 1, BASE + 32'h10,   3'd1, 32'h9999BEEF, 32'h0,        2, 2'b00);
    add_vec(1, 0, BASE + 32'h10,   3'd2, 32'h0,        32'hA522BEEF, 2, 2'b00);
    add_vec(0, 1, BASE + 32'h20,   3'd2, 32'hCAFEF00D, 32'h0,        1, 2'b00);
    add_vec(0, 0, BASE + 32'h20,   3'd2, 32'h0,        32'hCAFEF00D, 1, 2'b00);
    add_vec(1, 1, BASE + 32'h0,    3'd2, 32'h01020304, 32'h0,        2, 2'b00);
    add_vec(1, 0, BASE + 32'h2,    3'd2, 32'h0,        ERR_EN ? 32'h0 : 32'h01020304, 2, ERESP);
    add_vec(1, 0, BASE + 32'h1000, 3'd2, 32'h0,        32'h0,        2, ERESP);
    add_vec(1, 1, BASE + 32'h1000, 3'd2, 32'hFFFFFFFF, 32'h0,        2, ERESP);
    add_vec(1, 1, BASE + 32'h3,    3'd1, 32'hAAAA5555, 32'h0,        2, ERESP);
    add_vec(1, 0, BASE + 32'h0,    3'd2, 32'h0,        ERR_EN ? 32'h01020304 : 32'hAAAA0304, 2, 2'b00);
    add_vec(0, 0, BASE + 32'h1000, 3'd2, 32'h0,        32'h0,        ERR_EN ? 2 : 1, ERESP);
    add_vec(0, 0, BASE - 32'h4,    3'd2, 32'h0,        32'h0,        ERR_EN ? 2 : 1, ERESP);

    foreach (vecs[i]) begin
      run_check($sformatf("vec%0d", i), vecs[i].s, vecs[i].wr, vecs[i].addr, vecs[i].size,
                vecs[i].wdata, vecs[i].exp_rd, vecs[i].exp_cyc, vecs[i].exp_resp);
      model(vecs[i].s, vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wdata, dmy_rd, dmy_resp, dmy_cyc);
    end

    // Zero-wait pipelined write then read of the same word.
    h_sel = 2'b01; h_trans = 2'b10; h_write = 1'b1; h_addr = BASE + 32'h24; h_size = 3'd2;
    h_wdata = 32'h0;
    @(posedge clk); #1;
    h_trans = 2'b10; h_write = 1'b0; h_wdata = 32'h5A5A_1234;
    @(negedge clk);
    chk("pipe_wr_ready", 32'(bus0.HREADYOUT), 32'h1);
    chk("pipe_wr_resp", 32'(bus0.HRESP), 32'h0);
    @(posedge clk); #1;
    h_sel = 2'b00; h_trans = 2'b00; h_wdata = 32'h0;
    @(negedge clk);
    chk("pipe_rd_ready", 32'(bus0.HREADYOUT), 32'h1);
    chk("pipe_rd_data", bus0.HRDATA, 32'h5A5A_1234);
    @(posedge clk); #1;
    model(0, 1'b1, BASE + 32'h24, 3'd2, 32'h5A5A_1234, dmy_rd, dmy_resp, dmy_cyc);

    // BUSY with HSEL, then NONSEQ write without HSEL: no access, zero-wait OKAY.
    h_sel = 2'b11; h_trans = 2'b01; h_write = 1'b1; h_addr = BASE + 32'h10; h_size = 3'd2;
    @(posedge clk); #1;
    h_sel = 2'b00; h_trans = 2'b10; h_wdata = 32'h0BAD_0BAD;
    @(negedge clk);
    chk("busy_ready0", 32'(bus0.HREADYOUT), 32'h1);
    chk("busy_ready1", 32'(bus1.HREADYOUT), 32'h1);
    chk("busy_resp1", 32'(bus1.HRESP), 32'h0);
    chk("busy_rdata1", bus1.HRDATA, 32'h0);
    @(posedge clk); #1;
    h_trans = 2'b00;
    @(negedge clk);
    chk("nosel_ready1", 32'(bus1.HREADYOUT), 32'h1);
    chk("nosel_resp1", 32'(bus1.HRESP), 32'h0);
    @(posedge clk); #1;
    run_model("busy_readback1", 1, 1'b0, BASE + 32'h10, 3'd2, 32'h0);
    run_model("busy_readback0", 0, 1'b0, BASE + 32'h10, 3'd2, 32'h0);

    // Reset during the wait state of a write: write dropped, outputs idle.
    run_model("rstw_old", 1, 1'b1, BASE + 32'h28, 3'd2, 32'h0123_4567);
    h_sel = 2'b10; h_trans = 2'b10; h_write = 1'b1; h_addr = BASE + 32'h28; h_size = 3'd2;
    @(posedge clk); #1;
    h_sel = 2'b00; h_trans = 2'b00; h_wdata = 32'hFEED_FACE;
    rst = 1'b1;
    @(negedge clk);
    chk("rstw_in_wait", 32'(bus1.HREADYOUT), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstw_ready", 32'(bus1.HREADYOUT), 32'h1);
    chk("rstw_resp", 32'(bus1.HRESP), 32'h0);
    chk("rstw_rdata", bus1.HRDATA, 32'h0);
    @(posedge clk); #1;
    run_model("rstw_readback", 1, 1'b0, BASE + 32'h28, 3'd2, 32'h0);

    // Randomized transfers against the model.
    for (int n = 0; n < 400; n++) begin
      int          s;
      bit          wr;
      logic [2:0]  size;
      logic [31:0] addr;
      int          pick;
      s    = int'($urandom_range(0, 1));
      wr   = 1'($urandom_range(0, 1));
      size = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      pick = int'($urandom_range(0, 19));
      if (pick == 0)      addr = BASE + 32'h1000 + 32'($urandom_range(0, 63));
      else if (pick == 1) addr = BASE - 32'($urandom_range(1, 64));
      else                addr = BASE + 32'($urandom_range(0, 63));
      run_model($sformatf("rnd%0d", n), s, wr, addr, size, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
